// File: rtl/fib_disp_pkg.sv
// Shared definitions for the Fibonacci display engine: segment patterns,
// converter state encoding and small elaboration-time helpers.
package fib_disp_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int dec_max(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter; one bit per cycle,
// result valid while done is high.
module bin2bcd_seq
  import fib_disp_pkg::*;
#(
  parameter int VAL_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_t      state_reg, state_next;
  logic [VAL_W-1:0] shift_reg, shift_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BCD_W-1:0] bcd_adj;

  // Pre-shift correction keeps every nibble a valid decimal digit after doubling
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = bin;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(VAL_W - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/fib_disp_core.sv
// Single-clock Fibonacci display engine driving a multiplexed common-anode
// 7-segment display. Optional feature macro: LEADING_ZERO_BLANK_EN.
module fib_disp_core
  import fib_disp_pkg::*;
#(
  parameter  int N_DIGITS    = 4,
  parameter  int REFRESH_DIV = 100_000,
  parameter  int STEP_DIV    = 10_000_000,
  parameter  int OVF_MODE    = 0,
  localparam int VAL_W       = $clog2(10**N_DIGITS)
) (
  input  logic                clk_100,
  input  logic                reset,
  input  logic                run,
  output logic [VAL_W-1:0]    fn,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int BCD_W  = 4 * N_DIGITS;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [VAL_W:0] MAX_B = (VAL_W + 1)'(dec_max(N_DIGITS));

  logic [REF_W-1:0]  ref_cnt_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic              refresh_tick, step_tick;

  logic [VAL_W-1:0]  a_reg, a_next;
  logic [VAL_W:0]    b_reg, b_next, sum;
  logic              ovf_reg, ovf_next;
  logic              conv_req_reg;

  logic              conv_busy, conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [BCD_W-1:0]  disp_reg;

  logic [IDX_W-1:0]    idx_reg;
  logic [N_DIGITS-1:0] an_reg, an_next, blank_mask;
  logic [6:0]          seg_reg;
  logic [3:0]          sel_nib;
  logic                sel_blank;

  assign refresh_tick = (ref_cnt_reg == REF_W'(REFRESH_DIV - 1));
  assign step_tick    = (step_cnt_reg == STEP_W'(STEP_DIV - 1));

  always_ff @(posedge clk_100) begin
    if (reset) begin
      ref_cnt_reg  <= '0;
      step_cnt_reg <= '0;
    end else begin
      ref_cnt_reg  <= refresh_tick ? '0 : ref_cnt_reg + 1'b1;
      step_cnt_reg <= step_tick ? '0 : step_cnt_reg + 1'b1;
    end
  end

  assign sum = {1'b0, a_reg} + b_reg;

  always_comb begin
    a_next   = a_reg;
    b_next   = b_reg;
    ovf_next = ovf_reg;
    if (step_tick && run && !conv_busy) begin
      if (b_reg <= MAX_B) begin
        a_next = b_reg[VAL_W-1:0];
        b_next = sum;
      end else begin
        ovf_next = 1'b1;
        if (OVF_MODE == 0) begin
          a_next = '0;
          b_next = {{VAL_W{1'b0}}, 1'b1};
        end
      end
    end
  end

  // A change of a raises a request that stays pending until the converter is idle
  always_ff @(posedge clk_100) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= {{VAL_W{1'b0}}, 1'b1};
      ovf_reg      <= 1'b0;
      conv_req_reg <= 1'b1;
    end else begin
      a_reg   <= a_next;
      b_reg   <= b_next;
      ovf_reg <= ovf_next;
      if (a_next != a_reg) begin
        conv_req_reg <= 1'b1;
      end else if (!conv_busy) begin
        conv_req_reg <= 1'b0;
      end
    end
  end

  bin2bcd_seq #(
    .VAL_W    (VAL_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk_100 (clk_100),
    .reset   (reset),
    .start   (conv_req_reg),
    .bin     (a_reg),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_ff @(posedge clk_100) begin
    if (reset) begin
      disp_reg <= '0;
    end else if (conv_done) begin
      disp_reg <= conv_bcd;
    end
  end

  genvar gi;
  generate
`ifdef LEADING_ZERO_BLANK_EN
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = (disp_reg[BCD_W-1:4*gi] == '0);
      end
    end
`else
    assign blank_mask = '0;
`endif
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_an
      assign an_next[gi] = (idx_reg != IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sel_nib   = disp_reg[4*i +: 4];
        sel_blank = blank_mask[i];
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      idx_reg <= '0;
      an_reg  <= ~(N_DIGITS'(1));
      seg_reg <= SEG_0;
    end else begin
      if (refresh_tick) begin
        idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end
      an_reg  <= an_next;
      seg_reg <= sel_blank ? SEG_BLANK : seg_decode(sel_nib);
    end
  end

  assign fn  = a_reg;
  assign ovf = ovf_reg;
  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_fib_disp_core.sv
// Bench for fib_disp_core: wrap and hold instances side by side, a cycle
// model built from the sequence rules, directed tables and random run.
module tb_fib_disp_core;

  localparam int N_DIGITS    = 4;
  localparam int REFRESH_DIV = 4;
  localparam int STEP_DIV    = 64;
  localparam int LAT         = 16;
  localparam int MAXV        = 9999;

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b1;
  logic        run     = 1'b0;
  logic [13:0] fn_w, fn_h;
  logic        ovf_w, ovf_h;
  logic [6:0]  seg_w, seg_h;
  logic [3:0]  an_w, an_h;

  fib_disp_core #(.N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV), .STEP_DIV(STEP_DIV), .OVF_MODE(0))
    dut_wrap (.clk_100(clk_100), .reset(reset), .run(run), .fn(fn_w), .ovf(ovf_w), .seg(seg_w), .an(an_w));
  fib_disp_core #(.N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV), .STEP_DIV(STEP_DIV), .OVF_MODE(1))
    dut_hold (.clk_100(clk_100), .reset(reset), .run(run), .fn(fn_h), .ovf(ovf_h), .seg(seg_h), .an(an_h));

  always #5 clk_100 = ~clk_100;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int value, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && value < p) return 7'h7F;
`endif
    return seg_of((value / p) % 10);
  endfunction

  // Reference model: index 0 = wrap instance, 1 = hold instance
  int         ma[2], mb[2], movf[2], mdisp[2];
  int         pend_on[2], pend_t[2], pend_v[2];
  int         midx, mstep, mref, tb_cyc;
  logic [3:0] m_an;
  logic [6:0] m_seg[2];

  initial begin
    bit r, u;
    int old;
    tb_cyc = 0;
    forever begin
      @(posedge clk_100);
      r = reset;
      u = run;
      #1;
      if (r) begin
        tb_cyc = 0;
        for (int m = 0; m < 2; m++) begin
          ma[m] = 0; mb[m] = 1; movf[m] = 0; mdisp[m] = 0; pend_on[m] = 0;
          m_seg[m] = seg_of(0);
        end
        midx = 0; mstep = 0; mref = 0; m_an = 4'b1110;
      end else begin
        tb_cyc++;
        m_an = ~(4'b0001 << midx);
        for (int m = 0; m < 2; m++) begin
          m_seg[m] = exp_seg(mdisp[m], midx);
          if (pend_on[m] != 0 && tb_cyc == pend_t[m]) begin
            mdisp[m]   = pend_v[m];
            pend_on[m] = 0;
          end
          if (mstep == STEP_DIV - 1 && u) begin
            old = ma[m];
            if (mb[m] <= MAXV) begin
              ma[m] = mb[m];
              mb[m] = old + mb[m];
            end else begin
              movf[m] = 1;
              if (m == 0) begin
                ma[m] = 0;
                mb[m] = 1;
              end
            end
            if (ma[m] != old) begin
              pend_on[m] = 1;
              pend_t[m]  = tb_cyc + LAT;
              pend_v[m]  = ma[m];
            end
          end
        end
        if (mref == REFRESH_DIV - 1) midx = (midx + 1) % N_DIGITS;
        mstep = (mstep + 1) % STEP_DIV;
        mref  = (mref + 1) % REFRESH_DIV;
      end
      chk("mon_fn_wrap",  fn_w,  ma[0]);
      chk("mon_ovf_wrap", ovf_w, movf[0]);
      chk("mon_an_wrap",  an_w,  m_an);
      chk("mon_seg_wrap", seg_w, m_seg[0]);
      chk("mon_fn_hold",  fn_h,  ma[1]);
      chk("mon_ovf_hold", ovf_h, movf[1]);
      chk("mon_an_hold",  an_h,  m_an);
      chk("mon_seg_hold", seg_h, m_seg[1]);
    end
  end

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (tb_cyc < t && guard < 100000) begin
      @(negedge clk_100);
      guard++;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk_100);
    reset = 1'b0;
  endtask

  task automatic check_display(input int vw, input int vh);
    logic [3:0] tgt;
    bit found;
    for (int d = 0; d < N_DIGITS; d++) begin
      tgt   = ~(4'b0001 << d);
      found = 1'b0;
      for (int k = 0; k < 3 * N_DIGITS * REFRESH_DIV && !found; k++) begin
        if (an_w == tgt) found = 1'b1;
        else @(negedge clk_100);
      end
      chk("disp_an_found", found, 1);
      chk("disp_seg_wrap", seg_w, exp_seg(vw, d));
      chk("disp_seg_hold", seg_h, exp_seg(vh, d));
    end
  endtask

  typedef struct {
    int steps;
    int fn_w;
    int fn_h;
    int ovf_w;
    int ovf_h;
    bit disp;
  } vec_t;

  initial begin
    vec_t       tbl[12];
    logic [3:0] an_seq[5];
    logic [3:0] prev;
    bit         found;
    int         rst_at, rst_len;

    tbl[0]  = '{1,  1,    1,    0, 0, 1'b0};
    tbl[1]  = '{2,  1,    1,    0, 0, 1'b0};
    tbl[2]  = '{3,  2,    2,    0, 0, 1'b0};
    tbl[3]  = '{5,  5,    5,    0, 0, 1'b0};
    tbl[4]  = '{8,  21,   21,   0, 0, 1'b1};
    tbl[5]  = '{13, 233,  233,  0, 0, 1'b0};
    tbl[6]  = '{19, 4181, 4181, 0, 0, 1'b1};
    tbl[7]  = '{20, 6765, 6765, 0, 0, 1'b1};
    tbl[8]  = '{21, 0,    6765, 1, 1, 1'b1};
    tbl[9]  = '{22, 1,    6765, 1, 1, 1'b0};
    tbl[10] = '{23, 1,    6765, 1, 1, 1'b0};
    tbl[11] = '{24, 2,    6765, 1, 1, 1'b0};
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011;
    an_seq[3] = 4'b0111; an_seq[4] = 4'b1110;

    // Reset held for three edges, then released with run high
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    reset = 1'b0;
    run   = 1'b1;
    chk("rst_fn",  fn_w,  0);
    chk("rst_ovf", ovf_w, 0);
    chk("rst_an",  an_w,  4'b1110);
    chk("rst_seg", seg_w, 7'b1000000);
    wait_cyc(LAT + 1);
    check_display(0, 0);

    for (int i = 0; i < 12; i++) begin
      wait_cyc(tbl[i].steps * STEP_DIV);
      chk("tbl_fn_wrap",  fn_w,  tbl[i].fn_w);
      chk("tbl_fn_hold",  fn_h,  tbl[i].fn_h);
      chk("tbl_ovf_wrap", ovf_w, tbl[i].ovf_w);
      chk("tbl_ovf_hold", ovf_h, tbl[i].ovf_h);
      if (tbl[i].disp) begin
        wait_cyc(tbl[i].steps * STEP_DIV + LAT + 1);
        check_display(tbl[i].fn_w, tbl[i].fn_h);
      end
    end

    // Pause at 233 across five step ticks while the scan keeps running
    do_reset(3);
    wait_cyc(13 * STEP_DIV);
    chk("pause_fn_start", fn_w, 233);
    run = 1'b0;
    found = 1'b0;
    prev  = an_w;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_100);
      if (an_w == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = an_w;
    end
    chk("pause_an_sync", found, 1);
    for (int j = 1; j < 5; j++) begin
      repeat (REFRESH_DIV) @(negedge clk_100);
      chk("pause_an_seq", an_w, an_seq[j]);
    end
    wait_cyc(18 * STEP_DIV + 2);
    chk("pause_fn_wrap", fn_w, 233);
    chk("pause_fn_hold", fn_h, 233);
    run = 1'b1;

    // Reset while the converter is mid-shift on 1597
    do_reset(3);
    wait_cyc(17 * STEP_DIV);
    chk("shift_fn_before", fn_w, 1597);
    wait_cyc(17 * STEP_DIV + 5);
    do_reset(2);
    chk("shift_rst_fn",  fn_w,  0);
    chk("shift_rst_ovf", ovf_w, 0);
    chk("shift_rst_hold", fn_h, 0);
    wait_cyc(LAT + 1);
    check_display(0, 0);

    // Random run pattern with one reset pulse of random length
    rst_at  = $urandom_range(1500, 3000);
    rst_len = $urandom_range(1, 3);
    for (int c = 0; c < 4500; c++) begin
      @(negedge clk_100);
      run = ($urandom_range(0, 7) != 0);
      if (c == rst_at) reset = 1'b1;
      if (c == rst_at + rst_len) reset = 1'b0;
    end

    @(negedge clk_100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
